// File: rtl/tdc_pkg.sv
// Shared types and defaults for the TDC measurement controller.
package tdc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } tdc_state_t;

    localparam int TDC_N_DELAY       = 32;
    localparam int TDC_LOG_AVG       = 3;
    localparam int TDC_ARM_CYCLES    = 4;
    localparam int TDC_SETTLE_CYCLES = 2;

    // Enough bits to hold a popcount of 0..n_delay inclusive.
    function automatic int tdc_count_width(input int n_delay);
        return $clog2(n_delay + 1);
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer-code decoder: transition count plus bubble detect.
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int N_DELAY = TDC_N_DELAY,
    parameter int CW      = tdc_count_width(N_DELAY)
) (
    input  logic [N_DELAY-1:0] code,
    output logic [CW-1:0]      count,
    output logic               bubble
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_DELAY; i++) begin
            count = count + CW'(code[i]);
        end
    end

    // A clean code is 2^k-1, so adding one clears every set bit.
    assign bubble = (code & (code + N_DELAY'(1))) != '0;

endmodule

// File: rtl/tdc_sequencer.sv
// Drives the delay-line start pulse, captures 2^LOG_AVG samples and reports avg/min/max/bubble.
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter int N_DELAY       = TDC_N_DELAY,
    parameter int CW            = tdc_count_width(N_DELAY),
    parameter int LOG_AVG       = TDC_LOG_AVG,
    parameter int ARM_CYCLES    = TDC_ARM_CYCLES,
    parameter int SETTLE_CYCLES = TDC_SETTLE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    output logic               tdc_start,
    input  logic [N_DELAY-1:0] tdc_count,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CW-1:0]      res_avg,
    output logic [CW-1:0]      res_min,
    output logic [CW-1:0]      res_max,
    output logic               res_bubble,
    output logic               busy
);

    localparam int AW        = CW + LOG_AVG;
    localparam int PHASE_MAX = (ARM_CYCLES > SETTLE_CYCLES) ? ARM_CYCLES : SETTLE_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam logic [PW-1:0] ARM_LAST    = PW'(ARM_CYCLES - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);

    tdc_state_t         state;
    logic [PW-1:0]      phase;
    logic [LOG_AVG-1:0] sample_idx;
    logic [AW-1:0]      acc;
    logic [CW-1:0]      min_cnt;
    logic [CW-1:0]      max_cnt;
    logic               bubble_seen;

    logic [CW-1:0]      sample_count;
    logic               sample_bubble;
    logic [AW-1:0]      acc_next;
    logic [CW-1:0]      min_next;
    logic [CW-1:0]      max_next;
    logic               bubble_next;

    tdc_therm_decode #(
        .N_DELAY (N_DELAY),
        .CW      (CW)
    ) u_decode (
        .code   (tdc_count),
        .count  (sample_count),
        .bubble (sample_bubble)
    );

    // Running statistics including the sample being captured this cycle.
    always_comb begin
        acc_next    = acc + AW'(sample_count);
        min_next    = (sample_count < min_cnt) ? sample_count : min_cnt;
        max_next    = (sample_count > max_cnt) ? sample_count : max_cnt;
        bubble_next = bubble_seen | sample_bubble;
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            phase       <= '0;
            sample_idx  <= '0;
            acc         <= '0;
            min_cnt     <= '1;
            max_cnt     <= '0;
            bubble_seen <= 1'b0;
            tdc_start   <= 1'b0;
            res_valid   <= 1'b0;
            res_avg     <= '0;
            res_min     <= '0;
            res_max     <= '0;
            res_bubble  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state       <= S_ARM;
                        tdc_start   <= 1'b1;
                        phase       <= '0;
                        sample_idx  <= '0;
                        acc         <= '0;
                        min_cnt     <= '1;
                        max_cnt     <= '0;
                        bubble_seen <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (phase == ARM_LAST) begin
                        state     <= S_SETTLE;
                        tdc_start <= 1'b0;
                        phase     <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        state <= S_CAPTURE;
                        phase <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    acc         <= acc_next;
                    min_cnt     <= min_next;
                    max_cnt     <= max_next;
                    bubble_seen <= bubble_next;
                    // Results are latched once here so they stay frozen through backpressure.
                    if (sample_idx == {LOG_AVG{1'b1}}) begin
                        state      <= S_DONE;
                        res_valid  <= 1'b1;
                        res_avg    <= CW'(acc_next >> LOG_AVG);
                        res_min    <= min_next;
                        res_max    <= max_next;
                        res_bubble <= bubble_next;
                    end else begin
                        sample_idx <= sample_idx + 1'b1;
                        state      <= S_ARM;
                        tdc_start  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state     <= S_IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    tdc_start <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Self-checking bench for tdc_sequencer: directed vector table, random codes vs. a statistics model, reset corners.
module tb_tdc_sequencer;

    localparam int PERIOD  = 7;
    localparam int SAMPLES = 8;
    localparam int DONE_AT = SAMPLES * PERIOD + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        tdc_start;
    logic [31:0] tdc_count;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_avg;
    logic [5:0]  res_min;
    logic [5:0]  res_max;
    logic        res_bubble;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] codes [SAMPLES];

    typedef struct {
        string       name;
        logic [31:0] code_a;
        logic [31:0] code_b;
        logic [7:0]  b_mask;
        int          hold;
        bit          pulse;
        int          exp_avg;
        int          exp_min;
        int          exp_max;
        int          exp_bubble;
    } vec_t;

    vec_t vecs [5];

    tdc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .tdc_start  (tdc_start),
        .tdc_count  (tdc_count),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_avg    (res_avg),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_bubble (res_bubble),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Wait for IDLE, issue one request, feed codes[] at the capture slots and check everything cycle by cycle.
    task automatic apply_stimulus(input string name, input int hold, input bit pulse,
                                  input int exp_avg, input int exp_min, input int exp_max,
                                  input int exp_bubble);
        int   waited;
        int   bad_start, bad_valid, bad_ready, bad_busy, bad_stable;
        logic exp_start;
        logic [18:0] held;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output({name, " req_ready_before"}, int'(req_ready), 1);
        if (!req_ready) return;
        req_valid  = 1'b1;
        res_ready  = (hold == 0);
        tdc_count  = $urandom;
        bad_start  = -1;
        bad_valid  = -1;
        bad_ready  = -1;
        bad_busy   = -1;
        bad_stable = -1;
        held       = '0;
        for (int r = 1; r <= DONE_AT + hold; r++) begin
            @(negedge clk);
            req_valid = (pulse && r < DONE_AT) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_start = (r < DONE_AT) && (((r - 1) % PERIOD) < 4);
            if (tdc_start !== exp_start && bad_start < 0) bad_start = r;
            if (res_valid !== (r >= DONE_AT) && bad_valid < 0) bad_valid = r;
            if (req_ready !== 1'b0 && bad_ready < 0) bad_ready = r;
            if (busy !== 1'b1 && bad_busy < 0) bad_busy = r;
            tdc_count = (r % PERIOD == 0 && r < DONE_AT) ? codes[r / PERIOD - 1] : $urandom;
            if (r == DONE_AT) begin
                check_output({name, " res_avg"}, int'(res_avg), exp_avg);
                check_output({name, " res_min"}, int'(res_min), exp_min);
                check_output({name, " res_max"}, int'(res_max), exp_max);
                check_output({name, " res_bubble"}, int'(res_bubble), exp_bubble);
                held = {res_avg, res_min, res_max, res_bubble};
            end else if (r > DONE_AT && bad_stable < 0 &&
                         {res_avg, res_min, res_max, res_bubble} !== held) begin
                bad_stable = r;
            end
            if (r == DONE_AT + hold) res_ready = 1'b1;
        end
        @(negedge clk);
        check_output({name, " req_ready_after"}, int'(req_ready), 1);
        check_output({name, " res_valid_after"}, int'(res_valid), 0);
        check_output({name, " busy_after"}, int'(busy), 0);
        check_output({name, " tdc_start_bad_cycle"}, bad_start, -1);
        check_output({name, " res_valid_bad_cycle"}, bad_valid, -1);
        check_output({name, " req_ready_bad_cycle"}, bad_ready, -1);
        check_output({name, " busy_bad_cycle"}, bad_busy, -1);
        if (hold > 0) check_output({name, " results_unstable_cycle"}, bad_stable, -1);
        res_ready = 1'b0;
    endtask

    task automatic reset_mid_measurement();
        int waited;
        for (int k = 0; k < SAMPLES; k++) codes[k] = 32'h0000_00FF;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        req_valid = 1'b1;
        res_ready = 1'b1;
        // Third ARM phase spans relative cycles 15..18.
        for (int r = 1; r <= 2 * PERIOD + 2; r++) begin
            @(negedge clk);
            req_valid = 1'b0;
            tdc_count = $urandom;
        end
        check_output("mid_reset tdc_start_in_arm", int'(tdc_start), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("mid_reset tdc_start", int'(tdc_start), 0);
        check_output("mid_reset busy", int'(busy), 0);
        check_output("mid_reset res_valid", int'(res_valid), 0);
        check_output("mid_reset req_ready", int'(req_ready), 1);
        check_output("mid_reset res_avg", int'(res_avg), 0);
        res_ready = 1'b0;
    endtask

    initial begin
        int sum, mn, mx, bub, n, hold;

        vecs[0] = '{"constant",    32'h0000_00FF, 32'h0000_00FF, 8'h00, 0,  1'b0, 8,  8, 8,  0};
        vecs[1] = '{"alternating", 32'h0000_00FF, 32'h0000_000F, 8'h55, 0,  1'b0, 6,  4, 8,  0};
        vecs[2] = '{"extremes",    32'hFFFF_FFFF, 32'h0000_0000, 8'h01, 0,  1'b0, 28, 0, 32, 0};
        vecs[3] = '{"bubble",      32'h0000_00FF, 32'h0000_00F7, 8'h08, 0,  1'b0, 7,  7, 8,  1};
        vecs[4] = '{"backpressure",32'h0000_00FF, 32'h0000_000F, 8'hAA, 10, 1'b1, 6,  4, 8,  0};

        rst       = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        tdc_count = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_output("reset req_ready", int'(req_ready), 1);
        check_output("reset busy", int'(busy), 0);
        check_output("reset tdc_start", int'(tdc_start), 0);
        check_output("reset res_valid", int'(res_valid), 0);
        check_output("reset res_avg", int'(res_avg), 0);
        check_output("reset res_min", int'(res_min), 0);
        check_output("reset res_max", int'(res_max), 0);
        check_output("reset res_bubble", int'(res_bubble), 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < SAMPLES; k++)
                codes[k] = vecs[i].b_mask[k] ? vecs[i].code_b : vecs[i].code_a;
            apply_stimulus(vecs[i].name, vecs[i].hold, vecs[i].pulse,
                           vecs[i].exp_avg, vecs[i].exp_min, vecs[i].exp_max, vecs[i].exp_bubble);
        end

        reset_mid_measurement();
        for (int k = 0; k < SAMPLES; k++) codes[k] = 32'h0000_00FF;
        apply_stimulus("after_reset", 0, 1'b0, 8, 8, 8, 0);

        // Random codes: mostly clean thermometer codes, some arbitrary words.
        for (int it = 0; it < 6; it++) begin
            sum = 0;
            mn  = 1000;
            mx  = -1;
            bub = 0;
            for (int k = 0; k < SAMPLES; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    codes[k] = $urandom;
                end else begin
                    n = $urandom_range(0, 32);
                    codes[k] = 32'((64'd1 << n) - 64'd1);
                end
                n   = $countones(codes[k]);
                sum = sum + n;
                if (n < mn) mn = n;
                if (n > mx) mx = n;
                if (codes[k] != 32'((64'd1 << n) - 64'd1)) bub = 1;
            end
            hold = $urandom_range(0, 3);
            apply_stimulus($sformatf("random%0d", it), hold, 1'b1, sum / SAMPLES, mn, mx, bub);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
